// File: rtl/uart_tx_frame_arbiter_if.sv
// Purpose : request/UART-TX bundle for uart_tx_frame_arbiter (frame sources, byte strobe, status).
// Latency : none, wiring only.
// Backpr. : i_tx_active / i_tx_done from the UART pace the byte strobes; requests hold until acked.
// Ports   : slave = arbiter view, master = requesters + UART + status consumer view.
interface uart_tx_frame_arbiter_if #(
    parameter int NUM_REQ   = 3,
    parameter int MAX_BYTES = 12
);
    logic [NUM_REQ-1:0]             i_req;
    logic [NUM_REQ*4-1:0]           i_req_len;
    logic [NUM_REQ*MAX_BYTES*8-1:0] i_req_data;
    logic [NUM_REQ-1:0]             o_req_ack;
    logic                           o_tx_valid;
    logic [7:0]                     o_tx_data;
    logic                           i_tx_active;
    logic                           i_tx_done;
    logic                           o_busy;
    logic [1:0]                     o_grant_id;
    logic                           i_err_clr;
    logic                           o_timeout_err;

    modport slave (
        input  i_req, i_req_len, i_req_data, i_tx_active, i_tx_done, i_err_clr,
        output o_req_ack, o_tx_valid, o_tx_data, o_busy, o_grant_id, o_timeout_err
    );

    modport master (
        output i_req, i_req_len, i_req_data, i_tx_active, i_tx_done, i_err_clr,
        input  o_req_ack, o_tx_valid, o_tx_data, o_busy, o_grant_id, o_timeout_err
    );
endinterface

// File: rtl/uart_tx_frame_arbiter.sv
// Purpose : round-robin arbiter that latches one requester frame and feeds it byte-wise (LSB first,
//           optional XOR checksum) into a single UART TX; watchdog aborts frames on a stuck TX.
// Latency : ack one cycle after the grant edge; first strobe at least one cycle after the ack edge.
// Backpr. : strobes wait while i_tx_active; next byte only after i_tx_done; others wait in i_req.
// Ports   : i_clk, i_rst (async, active high); bus = uart_tx_frame_arbiter_if.slave.
module uart_tx_frame_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int MAX_BYTES    = 12,
    parameter int ADD_CHECKSUM = 1,
    parameter int TIMEOUT_CLKS = 20000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    uart_tx_frame_arbiter_if.slave  bus
);
    localparam int              DW       = MAX_BYTES * 8;
    localparam int              TW       = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [3:0]      MAX_LEN  = 4'(MAX_BYTES);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_DONE, CK_SEND, CK_WAIT} state_t;

    state_t               state_q;
    logic [DW-1:0]        data_q;
    logic [3:0]           rem_q;
    logic [7:0]           ck_q;
    logic [TW-1:0]        tmo_q;
    logic [1:0]           ptr_q;
    logic [1:0]           grant_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic                 valid_q;
    logic [7:0]           txd_q;
    logic                 busy_q;
    logic                 err_q;

    logic [NUM_REQ-1:0]   req_eff;
    logic                 win_vld_d;
    logic [1:0]           win_d;
    logic [3:0]           len_raw;
    logic [3:0]           len_d;
    logic [DW-1:0]        data_d;

    // A requester still sees its ack this cycle and has not yet dropped i_req;
    // masking it prevents a zero-length frame from being granted twice.
    assign req_eff = bus.i_req & ~ack_q;

    // First set request after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        win_vld_d = 1'b0;
        win_d     = ptr_q;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (!win_vld_d && req_eff[idx]) begin
                win_vld_d = 1'b1;
                win_d     = 2'(idx);
            end
        end
    end

    assign len_raw = bus.i_req_len[int'(win_d)*4 +: 4];
    assign len_d   = (len_raw > MAX_LEN) ? MAX_LEN : len_raw;
    assign data_d  = bus.i_req_data[int'(win_d)*DW +: DW];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            ck_q    <= '0;
            tmo_q   <= '0;
            ptr_q   <= 2'(NUM_REQ - 1);
            grant_q <= '0;
            ack_q   <= '0;
            valid_q <= 1'b0;
            txd_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_q   <= '0;
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_vld_d) begin
                        data_q  <= data_d;
                        rem_q   <= len_d;
                        ck_q    <= '0;
                        grant_q <= win_d;
                        ptr_q   <= win_d;
                        ack_q   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_d;
                        if (len_d != 4'd0) begin
                            state_q <= SEND;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (!bus.i_tx_active) begin
                        valid_q <= 1'b1;
                        txd_q   <= data_q[7:0];
                        data_q  <= data_q >> 8;
                        rem_q   <= rem_q - 4'd1;
                        ck_q    <= ck_q ^ data_q[7:0];
                        tmo_q   <= '0;
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (bus.i_tx_done) begin
                        if (rem_q != 4'd0) begin
                            state_q <= SEND;
                        end else if (ADD_CHECKSUM != 0) begin
                            state_q <= CK_SEND;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        // Stuck transmitter: drop the rest of the frame and its checksum.
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                CK_SEND: begin
                    if (!bus.i_tx_active) begin
                        valid_q <= 1'b1;
                        txd_q   <= ck_q;
                        tmo_q   <= '0;
                        state_q <= CK_WAIT;
                    end
                end
                CK_WAIT: begin
                    if (bus.i_tx_done) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (tmo_q == TMO_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
            // Clear wins over a timeout raised on the same edge.
            if (bus.i_err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.o_req_ack     = ack_q;
    assign bus.o_tx_valid    = valid_q;
    assign bus.o_tx_data     = txd_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_grant_id    = grant_q;
    assign bus.o_timeout_err = err_q;
endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// Purpose : directed scoreboard bench for uart_tx_frame_arbiter with a simple UART TX model.
// Latency : model returns i_tx_done 10 clocks after each strobe (or never, in stuck mode).
// Backpr. : i_tx_active held by the model per byte, plus an extra forced-busy window.
module tb_uart_tx_frame_arbiter;
    localparam int NR = 3;
    localparam int MB = 12;
    localparam int DW = MB * 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_frame_arbiter_if #(.NUM_REQ(NR), .MAX_BYTES(MB)) bus ();

    uart_tx_frame_arbiter #(
        .NUM_REQ(NR), .MAX_BYTES(MB), .ADD_CHECKSUM(1), .TIMEOUT_CLKS(50)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    logic model_active = 1'b0;
    logic force_active = 1'b0;
    logic never_done   = 1'b0;
    assign bus.i_tx_active = model_active | force_active;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobes = 0;
    int last_strobe_cyc = 0;
    logic last_active = 1'b0;

    byte unsigned    exp_q[$];
    logic [NR-1:0]   ack_exp[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // cycle counter and TX-busy seen by the DUT at each edge
    initial forever begin
        @(posedge clk);
        cyc++;
        last_active = bus.i_tx_active;
    end

    // monitor: pops the scoreboard whenever the DUT strobes or acks
    initial forever begin
        @(negedge clk);
        if (bus.o_tx_valid) begin
            strobes++;
            last_strobe_cyc = cyc;
            check("strobe_while_active", {31'd0, last_active}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe got %02h expected none", bus.o_tx_data);
            end else begin
                check("tx_byte", {24'd0, bus.o_tx_data}, {24'd0, exp_q.pop_front()});
            end
        end
        if (bus.o_req_ack != '0) begin
            if (ack_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack got %0b expected none", bus.o_req_ack);
            end else begin
                logic [NR-1:0] e;
                int gid;
                e = ack_exp.pop_front();
                gid = 0;
                for (int k = 0; k < NR; k++) if (e[k]) gid = k;
                check("req_ack", {29'd0, bus.o_req_ack}, {29'd0, e});
                check("grant_id", {30'd0, bus.o_grant_id}, 32'(gid));
            end
        end
    end

    // UART TX model
    initial forever begin
        @(negedge clk);
        if (bus.o_tx_valid) begin
            model_active = 1'b1;
            if (!never_done) begin
                repeat (9) @(negedge clk);
                bus.i_tx_done = 1'b1;
                @(negedge clk);
                bus.i_tx_done = 1'b0;
                model_active = 1'b0;
            end else begin
                @(negedge clk);
                model_active = 1'b0;
            end
        end
    end

    // requesters drop their request when acked
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < NR; k++) if (bus.o_req_ack[k]) bus.i_req[k] = 1'b0;
    end

    task automatic set_frame(input int k, input logic [3:0] len, input logic [DW-1:0] data);
        bus.i_req_len[k*4 +: 4]    = len;
        bus.i_req_data[k*DW +: DW] = data;
    endtask

    task automatic push_frame(input int k, input int nbytes, input logic [DW-1:0] data,
                              input byte unsigned ck);
        logic [NR-1:0] oh;
        oh = '0;
        oh[k] = 1'b1;
        ack_exp.push_back(oh);
        for (int i = 0; i < nbytes; i++) exp_q.push_back(data[i*8 +: 8]);
        if (nbytes > 0) exp_q.push_back(ck);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(exp_q.size() == 0 && ack_exp.size() == 0 && !bus.o_busy &&
                     !bus.i_tx_active && bus.i_req == '0) && n < budget);
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s_idle_timeout got pending=%0d expected 0", name, exp_q.size());
        end
    endtask

    task automatic wait_strobes(input int target, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (strobes < target && n < budget);
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL strobe_wait_timeout got %0d expected %0d", strobes, target);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d;
        int base;
        int dt;
        bus.i_req      = '0;
        bus.i_req_len  = '0;
        bus.i_req_data = '0;
        bus.i_tx_done  = 1'b0;
        bus.i_err_clr  = 1'b0;
        #1;
        check("rst_tx_valid", {31'd0, bus.o_tx_valid}, 32'd0);
        check("rst_busy", {31'd0, bus.o_busy}, 32'd0);
        check("rst_ack", {29'd0, bus.o_req_ack}, 32'd0);
        check("rst_err", {31'd0, bus.o_timeout_err}, 32'd0);
        check("rst_grant", {30'd0, bus.o_grant_id}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 1: single frame with checksum 0x46
        @(negedge clk);
        d = '0;
        d[31:0] = 32'h0112_BBEE;
        set_frame(0, 4'd4, d);
        push_frame(0, 4, d, 8'h46);
        bus.i_req[0] = 1'b1;
        wait_idle("t1", 200);
        check("t1_strobes", 32'(strobes), 32'd5);
        dt = cyc - last_strobe_cyc;
        check("t1_busy_drop", 32'(dt), 32'd10);

        // 2: three simultaneous requests, then 0 and 2 with pointer at 2
        do_reset();
        set_frame(0, 4'd1, DW'(8'hA0));
        set_frame(1, 4'd1, DW'(8'hA1));
        set_frame(2, 4'd1, DW'(8'hA2));
        push_frame(0, 1, DW'(8'hA0), 8'hA0);
        push_frame(1, 1, DW'(8'hA1), 8'hA1);
        push_frame(2, 1, DW'(8'hA2), 8'hA2);
        bus.i_req = 3'b111;
        wait_idle("t2a", 300);
        check("t2_grant_hold", {30'd0, bus.o_grant_id}, 32'd2);
        push_frame(0, 1, DW'(8'hA0), 8'hA0);
        push_frame(2, 1, DW'(8'hA2), 8'hA2);
        bus.i_req = 3'b101;
        wait_idle("t2b", 300);

        // 3: full 12-byte frame behind a busy transmitter, checksum 0x61
        do_reset();
        d = 96'hACDE_ADBE_EFDE_ADBE_EFAB_AACC;
        set_frame(1, 4'd12, d);
        push_frame(1, 12, d, 8'h61);
        base = strobes;
        force_active = 1'b1;
        bus.i_req[1] = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("t3_no_strobe_busy", 32'(strobes), 32'(base));
        force_active = 1'b0;
        wait_idle("t3", 400);
        check("t3_strobes", 32'(strobes - base), 32'd13);

        // 4: stuck transmitter, timeout 50 cycles after the strobe
        do_reset();
        never_done = 1'b1;
        d = '0;
        d[23:0] = 24'h33_2211;
        set_frame(0, 4'd3, d);
        ack_exp.push_back(3'b001);
        exp_q.push_back(8'h11);
        base = strobes;
        bus.i_req[0] = 1'b1;
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                #1;
                n++;
            end while (!bus.o_timeout_err && n < 200);
            dt = cyc - last_strobe_cyc;
        end
        check("t4_err_set", {31'd0, bus.o_timeout_err}, 32'd1);
        check("t4_err_delay", 32'(dt), 32'd50);
        check("t4_busy_after", {31'd0, bus.o_busy}, 32'd0);
        repeat (20) @(negedge clk);
        #1;
        check("t4_no_more_strobes", 32'(strobes - base), 32'd1);
        never_done = 1'b0;
        set_frame(1, 4'd1, DW'(8'h5A));
        push_frame(1, 1, DW'(8'h5A), 8'h5A);
        bus.i_req[1] = 1'b1;
        wait_idle("t4", 200);
        check("t4_err_sticky", {31'd0, bus.o_timeout_err}, 32'd1);
        @(negedge clk);
        bus.i_err_clr = 1'b1;
        @(negedge clk);
        bus.i_err_clr = 1'b0;
        #1;
        check("t4_err_clr", {31'd0, bus.o_timeout_err}, 32'd0);

        // 5: zero length, then clamped length 15
        do_reset();
        base = strobes;
        set_frame(0, 4'd0, DW'(8'h99));
        ack_exp.push_back(3'b001);
        bus.i_req[0] = 1'b1;
        wait_idle("t5a", 50);
        repeat (5) @(negedge clk);
        #1;
        check("t5_len0_strobes", 32'(strobes), 32'(base));
        check("t5_len0_busy", {31'd0, bus.o_busy}, 32'd0);
        for (int i = 0; i < MB; i++) d[i*8 +: 8] = 8'(i + 1);
        set_frame(1, 4'd15, d);
        push_frame(1, 12, d, 8'h0C);
        bus.i_req[1] = 1'b1;
        wait_idle("t5b", 400);
        check("t5_clamp_strobes", 32'(strobes - base), 32'd13);

        // 6: async reset during byte 3, then req0 first and req2 restarts
        do_reset();
        for (int i = 0; i < MB; i++) d[i*8 +: 8] = 8'(8'h10 + i);
        set_frame(2, 4'd12, d);
        ack_exp.push_back(3'b100);
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h12);
        base = strobes;
        bus.i_req[2] = 1'b1;
        wait_strobes(base + 3, 200);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", {31'd0, bus.o_tx_valid}, 32'd0);
        check("t6_rst_busy", {31'd0, bus.o_busy}, 32'd0);
        check("t6_rst_grant", {30'd0, bus.o_grant_id}, 32'd0);
        check("t6_rst_data", {24'd0, bus.o_tx_data}, 32'd0);
        check("t6_rst_ack", {29'd0, bus.o_req_ack}, 32'd0);
        set_frame(0, 4'd1, DW'(8'h77));
        bus.i_req = 3'b101;
        repeat (15) @(negedge clk);
        #1;
        check("t6_no_strobe_in_rst", 32'(strobes - base), 32'd3);
        check("t6_partial_consumed", 32'(exp_q.size()), 32'd0);
        push_frame(0, 1, DW'(8'h77), 8'h77);
        push_frame(2, 12, d, 8'h00);
        rst = 1'b0;
        wait_idle("t6", 500);
        check("t6_strobes", 32'(strobes - base), 32'd18);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_frame_arbiter.md
Name: uart_tx_frame_arbiter

Overview:
- Shares the single PLANK UART transmitter among NUM_REQ packet sources: channel feedback, ADC snapshot and temperature status.
- Each source presents a frame of up to MAX_BYTES bytes. The arbiter grants frames round-robin, latches the granted frame, and serializes it LSB-byte-first into the UART TX byte interface.
- An optional XOR checksum byte can be appended to each frame.
- A done-timeout watchdog guards against a stuck transmitter.

Parameters:
- NUM_REQ, 3, number of requesters (2..4).
- MAX_BYTES, 12, maximum frame payload in bytes; data bus per requester is MAX_BYTES*8 bits.
- ADD_CHECKSUM, 1, when 1, appends the XOR of all sent payload bytes after the payload.
- TIMEOUT_CLKS, 20000, number of clocks allowed in WAIT_DONE before the frame is aborted.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_req  in  NUM_REQ  per-requester frame request; level, held until the matching ack.
- i_req_len  in  NUM_REQ*4  per-requester byte count; slice k is [4k+3:4k].
- i_req_data  in  NUM_REQ*MAX_BYTES*8  per-requester frame; byte 0 is in the LSBs of slice k.
- o_req_ack  out  NUM_REQ  one-cycle pulse; the frame has been latched and the requester may change its data.
- o_tx_valid  out  1  one-cycle strobe to the UART TX (i_Tx_DV).
- o_tx_data  out  8  byte to transmit, valid with o_tx_valid.
- i_tx_active  in  1  UART TX busy.
- i_tx_done  in  1  UART TX byte-complete pulse.
- o_busy  out  1  high in every state except IDLE.
- o_grant_id  out  2  index of the frame in progress; holds the last value while in IDLE.
- i_err_clr  in  1  clears o_timeout_err.
- o_timeout_err  out  1  sticky flag: a frame was aborted by the timeout.

Behaviour:
- Reset (async, i_rst=1):
  - All outputs are 0.
  - State is IDLE.
  - RR pointer is NUM_REQ-1, so requester 0 has highest priority first.
  - Counters and checksum are 0.
- States: IDLE, SEND, WAIT_DONE, CK_SEND, CK_WAIT.
- IDLE:
  - On a clock with any i_req set, select the first set bit searching from pointer+1 upward, wrapping modulo NUM_REQ.
  - On that edge: latch data and length, clear the checksum, set o_grant_id, update the pointer to the winner, and assert o_req_ack[winner] for exactly the next cycle.
  - Length 0: ack only, no bytes sent, stay in IDLE.
  - Length greater than MAX_BYTES is clamped to MAX_BYTES.
  - Otherwise go to SEND. Ack-to-first-strobe latency is at least 1 cycle.
- SEND:
  - While i_tx_active=1, wait.
  - Otherwise, for one cycle: o_tx_valid=1, o_tx_data = latched[7:0]. Shift the latched data right by 8, decrement remaining, checksum ^= byte, go to WAIT_DONE.
- WAIT_DONE:
  - On i_tx_done: if remaining is nonzero go to SEND; else go to CK_SEND if ADD_CHECKSUM, otherwise IDLE.
  - The timeout counter clears on entry and counts every cycle. When it reaches TIMEOUT_CLKS-1 without i_tx_done: set o_timeout_err, discard the rest of the frame (no checksum), go to IDLE.
- CK_SEND / CK_WAIT: identical to SEND / WAIT_DONE with o_tx_data = checksum; on completion or timeout go to IDLE.
- i_tx_done outside WAIT_DONE/CK_WAIT is ignored.
- Requests are sampled only in IDLE. A requester that drops i_req before ack loses its turn silently. Requests arriving mid-frame wait; no frame is ever preempted.
- Simultaneous requests produce exactly one ack per frame; the others are served in RR order on subsequent frames.
- i_err_clr has priority over a same-cycle timeout set, so the flag stays 0.
- Reset mid-frame: immediate return to reset values; no further o_tx_valid; no ack for the interrupted frame.
- Back-to-back frames: IDLE re-arbitrates on the cycle after returning, with no extra idle cycle required.

Test Plan:
1. Req0 only, len=4, data bytes 0xEE,0xBB,0x12,0x01; TX model asserts done 10 clocks after each strobe → strobes with 0xEE,0xBB,0x12,0x01 then checksum 0x46; one ack[0]; o_busy drops after the last done.
2. Req0, req1, req2 all held with len=1 and data 0xA0/0xA1/0xA2 → frame order 0,1,2. Re-raise req0 and req2 together after the pointer is at 2 → order 0 then 2.
3. Req1 with len=12, data 0xACDEADBEEFDEADBEEFABAACC → 12 bytes LSB-first starting 0xCC,0xAA,0xAB, plus the XOR of all 12; no strobe while i_tx_active=1.
4. TX model never returns done, TIMEOUT_CLKS=50 → o_timeout_err=1 exactly 50 cycles after the first strobe; no further strobes; next request served normally; i_err_clr pulse clears the flag.
5. len=0 → ack pulse only, zero strobes. len=15 → exactly 12 payload bytes sent.
6. Assert i_rst during byte 3 of a 12-byte frame → outputs 0 asynchronously; after release, a pending req0 is acked first and its frame restarts from byte 0.
